// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared states, key codes and ALU op codes for the BCD calculator sequencer
package calc_pkg;

  typedef enum logic [2:0] {
    CARGA_A = 3'd0,
    CARGA_B = 3'd1,
    CALCULO = 3'd2,
    MUESTRA = 3'd3,
    ERROR   = 3'd4
  } estado_t;

  localparam logic [3:0] TECLA_SUMA  = 4'd10;
  localparam logic [3:0] TECLA_RESTA = 4'd11;
  localparam logic [3:0] TECLA_MULT  = 4'd12;
  localparam logic [3:0] TECLA_IGUAL = 4'd13;
  localparam logic [3:0] TECLA_CLEAR = 4'd14;

  localparam logic [1:0] OP_SUMA  = 2'b00;
  localparam logic [1:0] OP_RESTA = 2'b01;
  localparam logic [1:0] OP_MULT  = 2'b10;

  localparam logic [15:0] ERROR_DISPLAY = 16'hFFFF;
  localparam logic [2:0]  DIGITOS_MAX   = 3'd4;

  function automatic logic es_digito(input logic [3:0] t);
    return t <= 4'd9;
  endfunction

  function automatic logic es_operador(input logic [3:0] t);
    return (t == TECLA_SUMA) || (t == TECLA_RESTA) || (t == TECLA_MULT);
  endfunction

  function automatic logic [1:0] op_de_tecla(input logic [3:0] t);
    case (t)
      TECLA_RESTA: return OP_RESTA;
      TECLA_MULT:  return OP_MULT;
      default:     return OP_SUMA;
    endcase
  endfunction

endpackage

// File: rtl/registro_entrada_bcd.sv
// rtl/registro_entrada_bcd.sv - 4-digit BCD operand shift register with digit count
module registro_entrada_bcd
  import calc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        limpiar,
  input  logic        cargar_digito,
  input  logic        cargar_valor,
  input  logic [3:0]  digito,
  input  logic [15:0] valor_in,
  input  logic [2:0]  cuenta_in,
  output logic [15:0] valor,
  output logic [15:0] valor_sig,
  output logic        lleno,
  output logic        vacio
);

  logic [2:0] cuenta;
  logic [2:0] cuenta_sig;

  // Next value: clear wins, then whole-value load, then digit shift-in from the right
  always_comb begin
    valor_sig  = valor;
    cuenta_sig = cuenta;
    if (limpiar) begin
      valor_sig  = '0;
      cuenta_sig = '0;
    end else if (cargar_valor) begin
      valor_sig  = valor_in;
      cuenta_sig = cuenta_in;
    end else if (cargar_digito) begin
      valor_sig  = {valor[11:0], digito};
      cuenta_sig = cuenta + 3'd1;
    end
  end

  // Operand and count registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valor  <= '0;
      cuenta <= '0;
    end else begin
      valor  <= valor_sig;
      cuenta <= cuenta_sig;
    end
  end

  assign lleno = (cuenta == DIGITOS_MAX);
  assign vacio = (cuenta == 3'd0);

endmodule

// File: rtl/control_calculadora_bcd.sv
// rtl/control_calculadora_bcd.sv - keypad sequencer driving the BCD ALU and display
module control_calculadora_bcd
  import calc_pkg::*;
#(
  parameter int LAT_ALU = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tecla_valida,
  input  logic [3:0]  tecla_codigo,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [1:0]  alu_op,
  input  logic [15:0] alu_resultado,
  input  logic        alu_cout,
  input  logic        alu_neg,
  input  logic        alu_ovf,
  output logic [15:0] display,
  output logic        neg_led,
  output logic        error_led,
  output logic        busy,
  output logic        resultado_valido
);

  localparam logic [3:0] ESPERA_INI = 4'(LAT_ALU - 1);

  estado_t     estado, estado_sig;
  logic [3:0]  espera;
  logic        es_dig, es_op, es_igual, es_clear, expira;
  logic        a_limpiar, a_digito, a_cargar, b_limpiar, b_digito;
  logic [15:0] a_val, a_sig, b_sig, disp_calc, disp_sig;
  logic [2:0]  a_cnt;
  logic        a_lleno, a_vacio_unused, b_lleno, b_vacio;
  logic [1:0]  op_sig;
  logic        neg_sig, err_sig, valido_sig;

  assign es_dig   = tecla_valida && es_digito(tecla_codigo);
  assign es_op    = tecla_valida && es_operador(tecla_codigo);
  assign es_igual = tecla_valida && (tecla_codigo == TECLA_IGUAL);
  assign es_clear = tecla_valida && (tecla_codigo == TECLA_CLEAR);
  assign expira   = (espera == 4'd0);

  registro_entrada_bcd u_reg_a (
    .clk(clk), .rst(rst), .limpiar(a_limpiar), .cargar_digito(a_digito),
    .cargar_valor(a_cargar), .digito(tecla_codigo), .valor_in(a_val), .cuenta_in(a_cnt),
    .valor(alu_a), .valor_sig(a_sig), .lleno(a_lleno), .vacio(a_vacio_unused)
  );

  registro_entrada_bcd u_reg_b (
    .clk(clk), .rst(rst), .limpiar(b_limpiar), .cargar_digito(b_digito),
    .cargar_valor(1'b0), .digito(tecla_codigo), .valor_in(16'h0000), .cuenta_in(3'd0),
    .valor(alu_b), .valor_sig(b_sig), .lleno(b_lleno), .vacio(b_vacio)
  );

  // Next state, operand register commands and next output values
  always_comb begin
    estado_sig = estado;
    a_limpiar  = 1'b0;
    a_digito   = 1'b0;
    a_cargar   = 1'b0;
    a_val      = display;
    a_cnt      = 3'd0;
    b_limpiar  = 1'b0;
    b_digito   = 1'b0;
    op_sig     = alu_op;
    disp_calc  = display;
    neg_sig    = neg_led;
    err_sig    = error_led;
    valido_sig = 1'b0;
    if (es_clear) begin
      estado_sig = CARGA_A;
      a_limpiar  = 1'b1;
      b_limpiar  = 1'b1;
      op_sig     = OP_SUMA;
      neg_sig    = 1'b0;
      err_sig    = 1'b0;
    end else begin
      case (estado)
        CARGA_A: begin
          if (es_dig) begin
            a_digito = !a_lleno;
          end else if (es_op) begin
            op_sig     = op_de_tecla(tecla_codigo);
            b_limpiar  = 1'b1;
            estado_sig = CARGA_B;
          end
        end
        CARGA_B: begin
          if (es_dig) begin
            b_digito = !b_lleno;
          end else if (es_op) begin
            if (b_vacio) op_sig = op_de_tecla(tecla_codigo);
          end else if (es_igual) begin
            estado_sig = CALCULO;
          end
        end
        CALCULO: begin
          if (expira) begin
            valido_sig = 1'b1;
            if (((alu_op == OP_SUMA) && alu_cout) || ((alu_op == OP_MULT) && alu_ovf)) begin
              estado_sig = ERROR;
              disp_calc  = ERROR_DISPLAY;
              err_sig    = 1'b1;
            end else begin
              estado_sig = MUESTRA;
              disp_calc  = alu_resultado;
              neg_sig    = (alu_op == OP_RESTA) && alu_neg;
            end
          end
        end
        MUESTRA: begin
          if (es_dig) begin
            a_cargar   = 1'b1;
            a_val      = {12'h000, tecla_codigo};
            a_cnt      = 3'd1;
            neg_sig    = 1'b0;
            estado_sig = CARGA_A;
          end else if (es_op && !neg_led) begin
            a_cargar   = 1'b1;
            a_val      = display;
            op_sig     = op_de_tecla(tecla_codigo);
            b_limpiar  = 1'b1;
            estado_sig = CARGA_B;
          end
        end
        ERROR:   ;
        default: estado_sig = CARGA_A;
      endcase
    end
  end

  // While entering digits the display follows the operand being typed
  assign disp_sig = (estado_sig == CARGA_A) ? a_sig :
                    (estado_sig == CARGA_B) ? b_sig : disp_calc;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) estado <= CARGA_A;
    else     estado <= estado_sig;
  end

  // Registered outputs and the ALU settle counter, reloaded whenever not computing
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      espera           <= ESPERA_INI;
      alu_op           <= OP_SUMA;
      display          <= '0;
      neg_led          <= 1'b0;
      error_led        <= 1'b0;
      busy             <= 1'b0;
      resultado_valido <= 1'b0;
    end else begin
      if (estado != CALCULO)  espera <= ESPERA_INI;
      else if (!expira)       espera <= espera - 4'd1;
      alu_op           <= op_sig;
      display          <= disp_sig;
      neg_led          <= neg_sig;
      error_led        <= err_sig;
      busy             <= (estado_sig == CALCULO);
      resultado_valido <= valido_sig;
    end
  end

endmodule
